// File: rtl/muldiv_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_seq_if
// Description : EX-stage request/response bundle for the multiply/divide
//               sequencer. The master modport drives MULT/DIV issue and
//               MFHI/MFLO reads. The slave modport returns the stall, busy,
//               read data and architectural HI/LO.
// Signals     : flush, Start_EX, InstrVal_EX, Op_EX, SrcA_EX[31:0],
//               SrcB_EX[31:0], MfReq_EX, MfSel_EX        (master -> slave)
//               MdStall, Busy, MfData_EX[31:0], Hi[31:0],
//               Lo[31:0]                                  (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface muldiv_seq_if;
    logic        flush;
    logic        Start_EX;
    logic        InstrVal_EX;
    logic        Op_EX;
    logic [31:0] SrcA_EX;
    logic [31:0] SrcB_EX;
    logic        MfReq_EX;
    logic        MfSel_EX;
    logic        MdStall;
    logic        Busy;
    logic [31:0] MfData_EX;
    logic [31:0] Hi;
    logic [31:0] Lo;

    modport master (
        output flush, Start_EX, InstrVal_EX, Op_EX, SrcA_EX, SrcB_EX,
               MfReq_EX, MfSel_EX,
        input  MdStall, Busy, MfData_EX, Hi, Lo
    );

    modport slave (
        input  flush, Start_EX, InstrVal_EX, Op_EX, SrcA_EX, SrcB_EX,
               MfReq_EX, MfSel_EX,
        output MdStall, Busy, MfData_EX, Hi, Lo
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_seq
// Description : Iterative signed 32-bit MULT/DIV sequencer that owns HI/LO.
//               An accepted operation runs 32 radix-2 iterations on operand
//               magnitudes, then takes one sign-fixup cycle that commits HI/LO.
//               Start-to-result latency is 33 cycles.
// Ports       : clk   - core clock, rising edge
//               reset - asynchronous, active-high, clears all state
//               bus   - muldiv_seq_if.slave (issue, MFHI/MFLO, stall, HI/LO)
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_seq (
    input  wire logic     clk,
    input  wire logic     reset,
    muldiv_seq_if.slave   bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FIXUP = 2'd2;

    logic [1:0]  r_state;
    logic [4:0]  r_count;
    logic [31:0] r_acc_hi;
    logic [31:0] r_acc_lo;
    logic [31:0] r_opnd;      // multiplicand (MULT) or divisor (DIV) magnitude
    logic        r_op;        // 0 = MULT, 1 = DIV
    logic        r_res_neg;   // product/quotient sign
    logic        r_rem_neg;   // remainder takes the dividend's sign
    logic        r_div0;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_idle;
    logic        w_req;
    logic        w_accept;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [32:0] w_mul_sum;
    logic [32:0] w_div_shift;
    logic [33:0] w_div_diff;
    logic        w_div_ok;
    logic [63:0] w_prod;
    logic [63:0] w_prod_s;
    logic [31:0] w_quo;
    logic [31:0] w_rem;

    assign w_idle   = (r_state == S_IDLE);
    assign w_req    = (bus.Start_EX | bus.MfReq_EX) & bus.InstrVal_EX & ~bus.flush;
    assign w_accept = w_idle & bus.Start_EX & bus.InstrVal_EX & ~bus.flush;

    // Two's-complement magnitudes; 32'h80000000 maps to itself, which is the
    // correct unsigned magnitude.
    assign w_mag_a = bus.SrcA_EX[31] ? (~bus.SrcA_EX + 32'd1) : bus.SrcA_EX;
    assign w_mag_b = bus.SrcB_EX[31] ? (~bus.SrcB_EX + 32'd1) : bus.SrcB_EX;

    // MULT step: the multiplier sits in acc_lo and shifts out LSB-first while
    // the product grows in from the top.
    assign w_mul_sum = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opnd} : 33'd0);

    // DIV step: shift the next dividend bit into the partial remainder and
    // trial-subtract. The partial remainder is always below the divisor, so
    // the 33-bit shifted value never overflows the 34-bit difference.
    assign w_div_shift = {r_acc_hi, r_acc_lo[31]};
    assign w_div_diff  = {1'b0, w_div_shift} - {2'b00, r_opnd};
    assign w_div_ok    = ~w_div_diff[33];

    assign w_prod   = {r_acc_hi, r_acc_lo};
    assign w_prod_s = r_res_neg ? (~w_prod + 64'd1) : w_prod;
    // A zero divisor leaves the dividend magnitude in the remainder, so the
    // remainder sign fixup gives back the original dividend in HI.
    assign w_quo    = r_div0 ? 32'hFFFF_FFFF
                             : (r_res_neg ? (~r_acc_lo + 32'd1) : r_acc_lo);
    assign w_rem    = r_rem_neg ? (~r_acc_hi + 32'd1) : r_acc_hi;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_count   <= 5'd0;
            r_acc_hi  <= 32'd0;
            r_acc_lo  <= 32'd0;
            r_opnd    <= 32'd0;
            r_op      <= 1'b0;
            r_res_neg <= 1'b0;
            r_rem_neg <= 1'b0;
            r_div0    <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op      <= bus.Op_EX;
                        r_res_neg <= bus.SrcA_EX[31] ^ bus.SrcB_EX[31];
                        r_rem_neg <= bus.SrcA_EX[31];
                        r_div0    <= bus.Op_EX & (bus.SrcB_EX == 32'd0);
                        r_count   <= 5'd31;
                        r_acc_hi  <= 32'd0;
                        r_acc_lo  <= bus.Op_EX ? w_mag_a : w_mag_b;
                        r_opnd    <= bus.Op_EX ? w_mag_b : w_mag_a;
                        r_state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (r_op) begin
                        r_acc_hi <= w_div_ok ? w_div_diff[31:0] : w_div_shift[31:0];
                        r_acc_lo <= {r_acc_lo[30:0], w_div_ok};
                    end else begin
                        {r_acc_hi, r_acc_lo} <= {w_mul_sum, r_acc_lo[31:1]};
                    end
                    r_count <= r_count - 5'd1;
                    if (r_count == 5'd0) begin
                        r_state <= S_FIXUP;
                    end
                end
                S_FIXUP: begin
                    if (r_op) begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end else begin
                        r_hi <= w_prod_s[63:32];
                        r_lo <= w_prod_s[31:0];
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.MdStall   = w_req & ~w_idle;
    assign bus.Busy      = ~w_idle;
    assign bus.MfData_EX = bus.MfSel_EX ? r_lo : r_hi;
    assign bus.Hi        = r_hi;
    assign bus.Lo        = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_seq
// Description : Self-checking bench for muldiv_seq. Expected HI/LO pairs are
//               computed by an arithmetic model when an operation is issued,
//               queued, and compared when the sequencer finishes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_seq;

    logic clk;
    logic reset;

    muldiv_seq_if bus ();

    muldiv_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int asserts_n;
    int fails_n;
    logic [63:0] sb_q[$];
    logic [31:0] last_hi;
    logic [31:0] last_lo;

    function automatic logic [63:0] model(input logic op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        sa = $signed(a);
        sb = $signed(b);
        if (!op) begin
            q = sa * sb;
            return q;
        end
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        asserts_n++;
        assert (obs === exp) else begin
            fails_n++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic op, input logic [31:0] a, input logic [31:0] b);
        bus.Start_EX    = 1'b1;
        bus.InstrVal_EX = 1'b1;
        bus.Op_EX       = op;
        bus.SrcA_EX     = a;
        bus.SrcB_EX     = b;
        sb_q.push_back(model(op, a, b));
        @(negedge clk);
        bus.Start_EX    = 1'b0;
        bus.InstrVal_EX = 1'b0;
    endtask

    task automatic wait_busy(output int n);
        n = 0;
        while (bus.Busy && n < 60) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic check_result(input string tag);
        logic [63:0] e;
        chk({tag, "_sb_nonempty"}, (sb_q.size() > 0), 64'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({tag, "_hi"}, bus.Hi, e[63:32]);
            chk({tag, "_lo"}, bus.Lo, e[31:0]);
            last_hi = e[63:32];
            last_lo = e[31:0];
        end
    endtask

    task automatic run_op(input string tag, input logic op, input logic [31:0] a,
                          input logic [31:0] b);
        int n;
        start_op(op, a, b);
        wait_busy(n);
        chk({tag, "_busy_cycles"}, n, 64'd33);
        check_result(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [63:0] e;
        asserts_n = 0;
        fails_n   = 0;
        last_hi   = 32'd0;
        last_lo   = 32'd0;
        bus.flush = 1'b0;  bus.Start_EX = 1'b0; bus.InstrVal_EX = 1'b0;
        bus.Op_EX = 1'b0;  bus.SrcA_EX  = 32'd0; bus.SrcB_EX     = 32'd0;
        bus.MfReq_EX = 1'b0; bus.MfSel_EX = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_busy",  bus.Busy,    64'd0);
        chk("rst_stall", bus.MdStall, 64'd0);
        chk("rst_hi",    bus.Hi,      64'd0);
        chk("rst_lo",    bus.Lo,      64'd0);

        // Directed arithmetic cases
        run_op("mul_7_m3",    1'b0, 32'd7,          32'hFFFF_FFFD);
        run_op("div_100_7",   1'b1, 32'd100,        32'd7);
        run_op("div_m7_2",    1'b1, 32'hFFFF_FFF9,  32'd2);
        run_op("div_5_0",     1'b1, 32'd5,          32'd0);
        run_op("div_m5_0",    1'b1, 32'hFFFF_FFFB,  32'd0);
        run_op("div_ovf",     1'b1, 32'h8000_0000,  32'hFFFF_FFFF);
        run_op("mul_min_min", 1'b0, 32'h8000_0000,  32'h8000_0000);
        run_op("div_7_m100",  1'b1, 32'd7,          32'hFFFF_FF9C);
        for (int i = 0; i < 6; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom;
            rb = (i == 5) ? 32'd3 : $urandom;
            run_op("rand", i[0], ra, rb);
        end

        // MFLO held in EX right after the accept stalls until commit
        start_op(1'b0, 32'd1234, 32'hFFFF_FF00);
        bus.MfReq_EX = 1'b1; bus.MfSel_EX = 1'b1; bus.InstrVal_EX = 1'b1;
        n = 0;
        while (bus.MdStall && n < 60) begin
            n++;
            @(negedge clk);
        end
        chk("mflo_stall_cycles", n, 64'd33);
        e = sb_q[0];
        chk("mflo_data", bus.MfData_EX, e[31:0]);
        bus.MfSel_EX = 1'b0;
        #1;
        chk("mfhi_data", bus.MfData_EX, e[63:32]);
        bus.MfReq_EX = 1'b0; bus.InstrVal_EX = 1'b0;
        check_result("mflo_op");
        @(negedge clk);

        // Start squashed by flush: nothing accepted, HI/LO untouched
        bus.Start_EX = 1'b1; bus.InstrVal_EX = 1'b1; bus.flush = 1'b1;
        bus.Op_EX = 1'b0; bus.SrcA_EX = 32'd9; bus.SrcB_EX = 32'd9;
        #1;
        chk("flush_stall", bus.MdStall, 64'd0);
        @(negedge clk);
        bus.Start_EX = 1'b0; bus.InstrVal_EX = 1'b0; bus.flush = 1'b0;
        chk("flush_busy", bus.Busy, 64'd0);
        chk("flush_hi",   bus.Hi,   last_hi);
        chk("flush_lo",   bus.Lo,   last_lo);
        @(negedge clk);
        chk("flush_busy_later", bus.Busy, 64'd0);

        // Second MULT while busy: stalls, then accepted at T+34
        start_op(1'b0, 32'd11, 32'd13);
        bus.Start_EX = 1'b1; bus.InstrVal_EX = 1'b1;
        bus.Op_EX = 1'b0; bus.SrcA_EX = 32'hFFFF_FFF0; bus.SrcB_EX = 32'd5;
        sb_q.push_back(model(1'b0, 32'hFFFF_FFF0, 32'd5));
        n = 0;
        while (bus.MdStall && n < 60) begin
            n++;
            @(negedge clk);
        end
        chk("b2b_stall_cycles", n, 64'd33);
        chk("b2b_idle_gap_busy", bus.Busy, 64'd0);
        check_result("b2b_first");
        @(negedge clk);
        bus.Start_EX = 1'b0; bus.InstrVal_EX = 1'b0;
        chk("b2b_second_accepted", bus.Busy, 64'd1);
        wait_busy(n);
        chk("b2b_second_busy_cycles", n, 64'd33);
        check_result("b2b_second");

        // Asynchronous reset in the middle of RUN
        start_op(1'b0, 32'd123, 32'd456);
        repeat (9) @(negedge clk);
        chk("mid_busy_before_reset", bus.Busy, 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("areset_busy",  bus.Busy,    64'd0);
        chk("areset_stall", bus.MdStall, 64'd0);
        chk("areset_hi",    bus.Hi,      64'd0);
        chk("areset_lo",    bus.Lo,      64'd0);
        void'(sb_q.pop_back());
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_busy", bus.Busy, 64'd0);
        run_op("mul_2_3_after_reset", 1'b0, 32'd2, 32'd3);

        chk("sb_drained", sb_q.size(), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", asserts_n, fails_n);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative signed multiply/divide sequencer owning the HI/LO register pair for the pipelined core. It accepts MULT/DIV operations issued from EX and runs them over 33 cycles using a shared shift/add-subtract datapath. It serves MFHI/MFLO reads and raises a stall request that the hazard logic ORs into AnyStall while a result is outstanding.

## Interface
- No parameters; operand width is fixed at 32.
- clk  in  1  core clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- flush  in  1  pipeline flush; squashes a Start_EX or MfReq_EX presented in the same cycle
- Start_EX  in  1  MULT/DIV in EX; qualified by InstrVal_EX
- InstrVal_EX  in  1  EX instruction valid
- Op_EX  in  1  0 = MULT, 1 = DIV
- SrcA_EX  in  32  multiplicand / dividend (signed)
- SrcB_EX  in  32  multiplier / divisor (signed)
- MfReq_EX  in  1  MFHI/MFLO in EX; qualified by InstrVal_EX
- MfSel_EX  in  1  0 = HI, 1 = LO
- MdStall  out  1  stall request to hazard unit
- Busy  out  1  operation in flight
- MfData_EX  out  32  combinational HI or LO per MfSel_EX
- Hi  out  32  architectural HI
- Lo  out  32  architectural LO

## Operation
- States: IDLE, RUN, FIXUP.
- Accept: IDLE & Start_EX & InstrVal_EX & ~flush. At that edge, latch operand magnitudes, the result sign (A[31]^B[31] for the quotient/product), the dividend sign (remainder sign), and Op. Load count = 31, then go to RUN.
- RUN, MULT: radix-2 shift-add on the 64-bit accumulator {acc_hi, acc_lo} using magnitudes; one multiplier bit per cycle.
- RUN, DIV: restoring division with magnitudes; one quotient bit per cycle; 33-bit trial subtract.
- Each RUN cycle decrements count. When count == 0, go to FIXUP.
- FIXUP: apply two's-complement negation per latched signs, then write Hi/Lo and return to IDLE.
  - MULT: {Hi,Lo} = signed 64-bit product.
  - DIV: Lo = quotient, truncated toward zero. Hi = remainder, carrying the dividend's sign.
- Divide by zero: Lo = 32'hFFFFFFFF, Hi = SrcA (the original dividend). Still takes the full latency.
- Overflow case: 32'h80000000 / 32'hFFFFFFFF gives Lo = 32'h80000000, Hi = 0.
- MdStall = (Start_EX | MfReq_EX) & InstrVal_EX & ~flush & (state != IDLE).
  - A stalled Start is accepted in the first cycle the state is IDLE.
  - A stalled MfReq reads the new Hi/Lo in that same cycle.
- MfData_EX = MfSel_EX ? Lo : Hi. It reflects committed registers only; there is no forwarding from FIXUP.
- Start_EX and MfReq_EX asserted together is illegal. Hazard logic guarantees this never happens.
- A flush while in RUN/FIXUP does not abort: the issuing instruction is older than any flush source.

## Timing
- Reset values: state IDLE, Busy 0, MdStall 0, Hi 0, Lo 0, count 0, accumulators 0.
- An asynchronous reset mid-RUN returns the block to IDLE immediately. Hi/Lo are cleared and the operation is lost.
- Accept edge T.
  - RUN occupies edges T+1..T+32.
  - FIXUP writes Hi/Lo at edge T+33.
  - Busy is high from after T through T+33 (33 cycles) and low after T+33.
- Start-to-result latency is 33 cycles. Back-to-back ops: the second Start is accepted at edge T+34 at the earliest.
- An MFHI issued the cycle after accept stalls 33 cycles, then reads the new value.
- Hi/Lo change only at the FIXUP edge or on reset.

## Test plan
- MULT 7 × -3 → after 33 cycles: Hi = 32'hFFFFFFFF, Lo = 32'hFFFFFFEB; Busy high for exactly 33 cycles.
- DIV 100 / 7 → Lo = 14, Hi = 2. DIV -7 / 2 → Lo = 32'hFFFFFFFD, Hi = 32'hFFFFFFFF.
- DIV 5 / 0 → Lo = 32'hFFFFFFFF, Hi = 5. DIV 32'h80000000 / -1 → Lo = 32'h80000000, Hi = 0.
- MULT, then MFLO held in EX the next cycle → MdStall high 33 cycles. MfData_EX = new Lo in the first non-stalled cycle.
- Start_EX with flush in the same cycle → no accept, Busy stays 0, Hi/Lo unchanged. Second MULT while busy → stalls, then accepted at T+34.
- Reset asserted at RUN cycle 10 → state IDLE, Busy 0, Hi = Lo = 0 immediately. A subsequent MULT 2 × 3 gives Lo = 6 correctly.
